hsid_mse_comp: RTL and testbench

Downstream consumer of the MSE stage: receives one MSE result per library reference (value, reference index, overflow flag) and tracks the best match (minimum MSE) and worst match (maximum MSE) across a library scan. It counts results against a programmed library size and asserts `done` once the scan is complete. Its outputs are the final classification result handed to the register/bus interface.

---
 rtl/hsid_pkg.sv | 17 +
 rtl/hsid_mse_comp_reg.sv | 41 ++++
 rtl/hsid_mse_comp.sv | 94 +++++++++
 tb/tb_hsid_mse_comp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared HSID definitions: datapath widths plus the MSE comparator FSM and
// compare-direction encodings.
package hsid_pkg;
  localparam int HSID_WORD_WIDTH        = 16;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } hsid_mse_comp_state_t;

  typedef enum logic {
    CMP_MIN = 1'b0,
    CMP_MAX = 1'b1
  } hsid_cmp_dir_t;
endpackage

// File: rtl/hsid_mse_comp_reg.sv
// Compare-and-hold register: keeps the strictly-better value seen so far
// (smaller for MIN, larger for MAX) together with its reference index.
module hsid_mse_comp_reg
  import hsid_pkg::*;
#(
  parameter hsid_cmp_dir_t DIR = CMP_MIN,
  parameter int            W   = HSID_WORD_WIDTH,
  parameter int            RW  = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_init,
  input  logic          i_load_first,
  input  logic          i_valid,
  input  logic [W-1:0]  i_value,
  input  logic [RW-1:0] i_ref,
  output logic [W-1:0]  o_value,
  output logic [RW-1:0] o_ref
);
  localparam logic [W-1:0] INIT_VAL = (DIR == CMP_MIN) ? {W{1'b1}} : {W{1'b0}};

  logic [W-1:0]  r_value;
  logic [RW-1:0] r_ref;
  logic          w_better;

  // Strict compare so that ties keep the earlier reference.
  assign w_better = (DIR == CMP_MIN) ? (i_value < r_value) : (i_value > r_value);

  always_ff @(posedge clk) begin
    if (i_rst || i_init) begin
      r_value <= INIT_VAL;
      r_ref   <= '0;
    end else if (i_valid && (i_load_first || w_better)) begin
      r_value <= i_value;
      r_ref   <= i_ref;
    end
  end

  assign o_value = r_value;
  assign o_ref   = r_ref;
endmodule

// File: rtl/hsid_mse_comp.sv
// MSE result consumer: tracks best (min) and worst (max) match over a library
// scan and flags completion once the programmed number of results arrived.
module hsid_mse_comp
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         start,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  input  logic [WORD_WIDTH-1:0]        mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref,
  input  logic                         mse_valid,
  input  logic                         mse_of,
  output logic [WORD_WIDTH-1:0]        mse_min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  output logic [WORD_WIDTH-1:0]        mse_max_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  output logic [HSP_LIBRARY_WIDTH-1:0] result_count,
  output logic                         busy,
  output logic                         done
);
  hsid_mse_comp_state_t         r_state, w_next;
  logic [HSP_LIBRARY_WIDTH-1:0] r_size, r_count, w_cnt_inc;
  logic                         r_busy, r_done;
  logic                         w_srst, w_accept, w_first;
  logic [WORD_WIDTH-1:0]        w_eff;

  assign w_srst    = rst || clear;
  // start wins over a coincident result: that sample is dropped.
  assign w_accept  = (r_state == ST_SCAN) && mse_valid && !start;
  assign w_first   = (r_count == '0);
  assign w_cnt_inc = r_count + 1'b1;
  assign w_eff     = mse_of ? {WORD_WIDTH{1'b1}} : mse_value;

  always_comb begin
    w_next = r_state;
    if (start)
      w_next = (library_size == '0) ? ST_DONE : ST_SCAN;
    else if (w_accept && (w_cnt_inc == r_size))
      w_next = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_state <= ST_IDLE;
      r_size  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_SCAN);
      r_done  <= (w_next == ST_DONE);
      if (start) begin
        r_size  <= library_size;
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= w_cnt_inc;
      end
    end
  end

  hsid_mse_comp_reg #(.DIR(CMP_MIN), .W(WORD_WIDTH), .RW(HSP_LIBRARY_WIDTH)) u_min (
    .clk          (clk),
    .i_rst        (w_srst),
    .i_init       (start),
    .i_load_first (w_first),
    .i_valid      (w_accept),
    .i_value      (w_eff),
    .i_ref        (mse_ref),
    .o_value      (mse_min_value),
    .o_ref        (mse_min_ref)
  );

  hsid_mse_comp_reg #(.DIR(CMP_MAX), .W(WORD_WIDTH), .RW(HSP_LIBRARY_WIDTH)) u_max (
    .clk          (clk),
    .i_rst        (w_srst),
    .i_init       (start),
    .i_load_first (w_first),
    .i_valid      (w_accept),
    .i_value      (w_eff),
    .i_ref        (mse_ref),
    .o_value      (mse_max_value),
    .o_ref        (mse_max_ref)
  );

  assign result_count = r_count;
  assign busy         = r_busy;
  assign done         = r_done;
endmodule

// File: tb/tb_hsid_mse_comp.sv
// Scoreboard bench for hsid_mse_comp: stimulus queues expected final results,
// a monitor compares them on every rising edge of done.
module tb_hsid_mse_comp;
  logic        clk = 1'b0;
  logic        rst, clear, start, mse_valid, mse_of;
  logic [7:0]  library_size, mse_ref;
  logic [15:0] mse_value;
  logic [15:0] mse_min_value, mse_max_value;
  logic [7:0]  mse_min_ref, mse_max_ref, result_count;
  logic        busy, done;

  typedef struct {
    logic [15:0] mn;
    logic [7:0]  mnr;
    logic [15:0] mx;
    logic [7:0]  mxr;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  hsid_mse_comp dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .library_size(library_size), .mse_value(mse_value), .mse_ref(mse_ref),
    .mse_valid(mse_valid), .mse_of(mse_of),
    .mse_min_value(mse_min_value), .mse_min_ref(mse_min_ref),
    .mse_max_value(mse_max_value), .mse_max_ref(mse_max_ref),
    .result_count(result_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // All inputs change on the falling edge, away from the sampling edge.
  task automatic drive(input logic st, input logic [7:0] sz, input logic v,
                       input logic [15:0] val, input logic [7:0] rf,
                       input logic of, input logic clr);
    @(negedge clk);
    start = st; library_size = sz; mse_valid = v;
    mse_value = val; mse_ref = rf; mse_of = of; clear = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd77, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic res(input logic [15:0] val, input logic [7:0] rf, input logic of);
    drive(1'b0, 8'd99, 1'b1, val, rf, of, 1'b0);
  endtask

  task automatic push(input logic [15:0] mn, input logic [7:0] mnr,
                      input logic [15:0] mx, input logic [7:0] mxr, input logic [7:0] cnt);
    exp_t e;
    e.mn = mn; e.mnr = mnr; e.mx = mx; e.mxr = mxr; e.cnt = cnt; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic snap(input string nm, input logic [15:0] mn, input logic [7:0] mnr,
                      input logic [15:0] mx, input logic [7:0] mxr, input logic [7:0] cnt,
                      input logic bz, input logic dn);
    @(posedge clk); #1;
    chk({nm, ".min"}, {16'h0, mse_min_value}, {16'h0, mn});
    chk({nm, ".min_ref"}, {24'h0, mse_min_ref}, {24'h0, mnr});
    chk({nm, ".max"}, {16'h0, mse_max_value}, {16'h0, mx});
    chk({nm, ".max_ref"}, {24'h0, mse_max_ref}, {24'h0, mxr});
    chk({nm, ".count"}, {24'h0, result_count}, {24'h0, cnt});
    chk({nm, ".busy"}, {31'h0, busy}, {31'h0, bz});
    chk({nm, ".done"}, {31'h0, done}, {31'h0, dn});
  endtask

  // Monitor: every done rise must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb.min", {16'h0, mse_min_value}, {16'h0, e.mn});
        chk("sb.min_ref", {24'h0, mse_min_ref}, {24'h0, e.mnr});
        chk("sb.max", {16'h0, mse_max_value}, {16'h0, e.mx});
        chk("sb.max_ref", {24'h0, mse_max_ref}, {24'h0, e.mxr});
        chk("sb.count", {24'h0, result_count}, {24'h0, e.cnt});
        chk("sb.done_cycle", cyc, e.cyc);
        chk("sb.busy_low", {31'h0, busy}, 32'd0);
      end
    end
    prev_done = done;
  end

  logic [15:0] d5 [5] = '{16'd40, 16'd15, 16'd70, 16'd70, 16'd25};

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; mse_valid = 1'b0; mse_of = 1'b0;
    library_size = 8'd0; mse_value = 16'd0; mse_ref = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    snap("reset", 16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Basic scan, back-to-back results
    drive(1'b1, 8'd4, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    snap("start_busy", 16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0, 1'b1, 1'b0);
    res(16'd50, 8'd1, 1'b0);
    res(16'd20, 8'd2, 1'b0);
    res(16'd90, 8'd3, 1'b0);
    res(16'd20, 8'd4, 1'b0);
    push(16'd20, 8'd2, 16'd90, 8'd3, 8'd4);
    idle(2);
    res(16'd1, 8'd7, 1'b0);
    snap("valid_in_done", 16'd20, 8'd2, 16'd90, 8'd3, 8'd4, 1'b0, 1'b1);

    // Overflow handling with gaps
    drive(1'b1, 8'd3, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    res(16'd10, 8'd1, 1'b0);
    idle(1);
    res(16'd7, 8'd2, 1'b1);
    idle(2);
    res(16'd5, 8'd3, 1'b0);
    push(16'd5, 8'd3, 16'hFFFF, 8'd2, 8'd3);
    idle(2);

    // Same data back-to-back, then with random gaps
    drive(1'b1, 8'd5, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      res(d5[i], 8'(i + 1), 1'b0);
      if (i == 4) push(16'd15, 8'd2, 16'd70, 8'd3, 8'd5);
    end
    idle(2);
    drive(1'b1, 8'd5, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 3));
      res(d5[i], 8'(i + 1), 1'b0);
      if (i == 4) push(16'd15, 8'd2, 16'd70, 8'd3, 8'd5);
    end
    idle(2);

    // Restart mid-scan; coincident sample dropped
    drive(1'b1, 8'd4, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    res(16'd11, 8'd1, 1'b0);
    res(16'd22, 8'd2, 1'b0);
    drive(1'b1, 8'd2, 1'b1, 16'd1, 8'd9, 1'b0, 1'b0);
    snap("restart", 16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0, 1'b1, 1'b0);
    res(16'd60, 8'd5, 1'b0);
    res(16'd80, 8'd6, 1'b0);
    push(16'd60, 8'd5, 16'd80, 8'd6, 8'd2);
    idle(2);

    // Clear mid-scan, then a result while idle
    drive(1'b1, 8'd3, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    res(16'd12, 8'd1, 1'b0);
    drive(1'b0, 8'd3, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    snap("clear", 16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);
    res(16'd3, 8'd4, 1'b0);
    snap("valid_in_idle", 16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Zero-size scan
    drive(1'b1, 8'd0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    push(16'hFFFF, 8'd0, 16'h0, 8'd0, 8'd0);
    idle(2);

    // Ties keep the first reference
    drive(1'b1, 8'd3, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    res(16'd30, 8'd1, 1'b0);
    res(16'd30, 8'd2, 1'b0);
    res(16'd30, 8'd3, 1'b0);
    push(16'd30, 8'd1, 16'd30, 8'd1, 8'd3);
    idle(3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
